// File: rtl/bin_to_dec_seq_ctrl.sv
// rtl/bin_to_dec_seq_ctrl.sv - sequential double-dabble binary-to-BCD converter with HEX drive
module bin_to_dec_seq_ctrl #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  CLOCK_50,
    input  logic                  KEY0,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [6:0]            HEX0,
    output logic [6:0]            HEX1,
    output logic [6:0]            HEX2
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int ND = (DIGITS > 3) ? DIGITS : 3;
    localparam int EW = 4 * ND;

    typedef enum logic [1:0] {IDLE, ADD3, SHIFT, DONE} state_t;

    state_t                state;
    logic [4*DIGITS-1:0]   s;
    logic [WIDTH-1:0]      sh;
    logic [CW-1:0]         cnt;
    logic [4*DIGITS-1:0]   s_shift;
    logic [EW-1:0]         bcd_ext;

    // The top bit of s falls off; the DIGITS constraint guarantees it is zero.
    assign s_shift = {s[4*DIGITS-2:0], sh[WIDTH-1]};

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
            s     <= '0;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh    <= bin;
                        s     <= '0;
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= ADD3;
                    end
                end
                ADD3: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (s[4*i +: 4] >= 4'd5)
                            s[4*i +: 4] <= s[4*i +: 4] + 4'd3;
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    s   <= s_shift;
                    sh  <= {sh[WIDTH-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        bcd   <= s_shift;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= ADD3;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Displays read only the committed result, never the scratch register.
    assign bcd_ext = EW'(bcd);
    assign HEX0 = seg7(bcd_ext[3:0]);
    assign HEX1 = (BLANK_LZ && bcd_ext[EW-1:4] == '0) ? 7'b1111111 : seg7(bcd_ext[7:4]);
    assign HEX2 = (BLANK_LZ && bcd_ext[EW-1:8] == '0) ? 7'b1111111 : seg7(bcd_ext[11:8]);
endmodule

// File: tb/tb_bin_to_dec_seq_ctrl.sv
// tb/tb_bin_to_dec_seq_ctrl.sv - randomized self-checking bench for bin_to_dec_seq_ctrl
module tb_bin_to_dec_seq_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy, done, busy_nb, done_nb;
    logic [11:0] bcd, bcd_nb;
    logic [6:0]  hex0, hex1, hex2, hex0_nb, hex1_nb, hex2_nb;

    int checks = 0;
    int failures = 0;
    int prev_bcd = 0;

    bin_to_dec_seq_ctrl #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b1)) u_dut (
        .CLOCK_50(clk), .KEY0(rst_n), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .HEX0(hex0), .HEX1(hex1), .HEX2(hex2)
    );

    bin_to_dec_seq_ctrl #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b0)) u_dut_nb (
        .CLOCK_50(clk), .KEY0(rst_n), .start(start), .bin(bin),
        .busy(busy_nb), .done(done_nb), .bcd(bcd_nb), .HEX0(hex0_nb), .HEX1(hex1_nb), .HEX2(hex2_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_bcd(input int v);
        return ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    function automatic int model_seg(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return int'(tbl[d]);
    endfunction

    function automatic int model_hex(input int v, input int pos, input bit blank);
        int d;
        d = (v / (pos == 0 ? 1 : (pos == 1 ? 10 : 100))) % 10;
        if (blank && pos > 0 && v < (pos == 1 ? 10 : 100)) return 7'h7f;
        return model_seg(d);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input int v);
        check("bcd", bcd, model_bcd(v));
        check("hex0", hex0, model_hex(v, 0, 1'b1));
        check("hex1", hex1, model_hex(v, 1, 1'b1));
        check("hex2", hex2, model_hex(v, 2, 1'b1));
        check("nb_bcd", bcd_nb, model_bcd(v));
        check("nb_hex0", hex0_nb, model_hex(v, 0, 1'b0));
        check("nb_hex1", hex1_nb, model_hex(v, 1, 1'b0));
        check("nb_hex2", hex2_nb, model_hex(v, 2, 1'b0));
    endtask

    // One conversion from an accepting edge; optionally pokes a busy-time start at k=5.
    task automatic run_conv(input int v, input bit poke);
        int k, busy_cnt, done_cnt;
        bin   = 8'(v);
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        while (!done && k < 40) begin
            if (k == 5) check("hold_bcd", bcd, prev_bcd);
            if (poke && k == 4) begin start = 1'b1; bin = 8'd99; end
            step();
            start = 1'b0;
            k++;
            if (busy) busy_cnt++;
        end
        check("done_latency", k, 16);
        check_result(v);
        for (int j = 0; j < 4; j++) begin
            step();
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        check("busy_cycles", busy_cnt, 17);
        check("extra_done", done_cnt, 0);
        prev_bcd = model_bcd(v);
    endtask

    initial begin
        int k, last, v;
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd, 0);
        check("rst_hex0", hex0, 7'h40);
        check("rst_hex1", hex1, 7'h7f);
        check("rst_hex2", hex2, 7'h7f);
        check("rst_nb_hex1", hex1_nb, 7'h40);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_conv(0, 1'b0);
        run_conv(15, 1'b0);
        run_conv(255, 1'b0);
        run_conv(7, 1'b0);
        run_conv(100, 1'b1);
        for (int i = 0; i < 16; i++) begin
            v = int'($urandom_range(0, 255));
            run_conv(v, 1'b0);
        end

        // Back-to-back with start held high.
        bin   = 8'd42;
        start = 1'b1;
        k = 0;
        while (!done && k < 40) begin step(); k++; end
        check("b2b_first", done, 1);
        last = 0;
        for (int p = 0; p < 3; p++) begin
            k = 0;
            step();
            check("b2b_hold", bcd, model_bcd(42));
            k = 1;
            while (!done && k < 40) begin
                step();
                k++;
                check("b2b_hold", bcd, model_bcd(42));
            end
            check("b2b_period", k, 18);
        end
        start = 1'b0;
        step();
        step();

        // Reset mid-conversion.
        bin   = 8'd200;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 8; j++) step();
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_bcd", bcd, 0);
        step();
        rst_n = 1'b1;
        prev_bcd = 0;
        run_conv(37, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bin_to_dec_seq_ctrl.md
# bin_to_dec_seq_ctrl

Sequential binary-to-decimal conversion controller for the seven-segment display path. It accepts a WIDTH-bit binary value on a start/busy/done handshake and runs a shift-add-3 (double-dabble) state machine over one bit per two clocks. It registers the resulting BCD digits and drives active-low HEX outputs with optional leading-zero blanking. It extends the 0–15 combinational converter to wider inputs and is the block that sequences conversions onto the HEX displays.

## Interface
- WIDTH, 8: binary input width; legal range 4..12.
- DIGITS, 3: number of BCD digits/HEX outputs. Must satisfy 10^DIGITS > 2^WIDTH − 1.
- BLANK_LZ, 1: 1 blanks leading-zero digits above HEX0; 0 shows all digits.
- CLOCK_50  input  1  system clock, rising edge.
- KEY0  input  1  reset, asynchronous, active-low.
- start  input  1  conversion request, sampled on a rising edge in IDLE.
- bin  input  WIDTH  unsigned value, captured on the accepting edge.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse; high only in DONE.
- bcd  output  4*DIGITS  registered result, digit 0 in [3:0].
- HEX0, HEX1, HEX2  output  7 each  active-low segments, bit order {g,f,e,d,c,b,a}.
  - Driven from digits 0, 1 and 2.
  - With DIGITS>3, the extra digits appear only on bcd.

## Operation
- States: IDLE, ADD3, SHIFT, DONE.
- IDLE, start=1: capture bin into shift register sh, clear scratch BCD register s, set cnt=WIDTH, go to ADD3. start=0: stay.
- ADD3: each 4-bit digit of s that is ≥5 gets +3; go to SHIFT.
- SHIFT: shift {s, sh} left by 1 and decrement cnt.
  - cnt after decrement ≠ 0: go to ADD3.
  - cnt = 0: go to DONE; load bcd from the shifted s on the same edge.
- DONE: done=1; go to IDLE unconditionally.
- start while busy (ADD3/SHIFT/DONE) is ignored, not queued. bin changes after capture have no effect.
- bcd and HEX hold their last result until the next DONE load.
- Decoding, active-low, bcd digit to segments:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Digit values >9 cannot occur; decode them as 1111111.
- Blanking with BLANK_LZ=1:
  - Digit i>0 shows 1111111 if it and all higher digits are 0.
  - HEX0 always shows its digit.
- HEX outputs are combinational from the bcd register only, so they are glitch-free with respect to the scratch register.

## Timing
- Reset (KEY0=0, async) forces:
  - state=IDLE, busy=0, done=0, bcd=0, s=0, sh=0, cnt=0
  - HEX0=1000000
  - HEX1=HEX2=1111111 (BLANK_LZ=1) or 1000000 (BLANK_LZ=0)
- Reset mid-conversion aborts the conversion. No done pulse, and bcd is cleared. Release is synchronous to the next edge, and the first start is accepted on the first edge with KEY0=1.
- Let E0 be the accepting edge (IDLE, start=1):
  - busy=1 from after E0 until after E(2·WIDTH+1).
  - bcd and HEX update at E(2·WIDTH).
  - done=1 between E(2·WIDTH) and E(2·WIDTH+1).
  - For WIDTH=8, bcd and done appear 16 cycles after E0.
- Back-to-back: start held high through DONE is accepted at the first edge in IDLE, i.e. E(2·WIDTH+2). Throughput is one conversion per 2·WIDTH+2 cycles.
- All arithmetic is per digit, 4 bits. The add-3 step never overflows a digit. The bit shifted out of the top digit is discarded, which is legal by the DIGITS constraint.

## Test plan
- Reset then bin=0, start pulse → done 16 cycles after the accepting edge; bcd=0x000; HEX0=1000000; HEX1=HEX2=1111111.
- bin=15 (8'h0F) → bcd=0x015; HEX0=0010010; HEX1=1111001; HEX2=1111111; busy high for exactly 17 cycles.
- bin=255 → bcd=0x255; HEX2=0100100; HEX1=HEX0=0010010. BLANK_LZ=0 with bin=7 → HEX2=HEX1=1000000, HEX0=1111000.
- Start bin=100, then pulse start with bin=99 at cycle 5 → the second start is ignored; result bcd=0x100 and only one done pulse.
- start held high continuously with bin=42 → done pulses every 18 cycles; bcd=0x042 throughout after the first load.
- Start bin=200, assert KEY0=0 at cycle 8 → busy=0, bcd=0, no done pulse. Release, start bin=37 → bcd=0x037 after 16 cycles.
